// File: rtl/intc_pkg.sv
// intc_pkg: shared constants and channel-mode type for the interrupt status register block
package intc_pkg;
  localparam int INTC_BUS_DW = 32;
  localparam int INTC_NCH_DEF = 8;
  localparam int INTC_TMO_W_DEF = 8;
  typedef enum logic {INTC_LEVEL = 1'b0, INTC_EDGE = 1'b1} intc_mode_e;
endpackage

// File: rtl/intc_rg_w1c_sts_if.sv
// intc_rg_w1c_sts_if: register write strobes, write data and register readback
interface intc_rg_w1c_sts_if
  import intc_pkg::*;
#(
  parameter int NCH = INTC_NCH_DEF,
  parameter int TMO_W = INTC_TMO_W_DEF
);
  logic sts_we_i;
  logic ovf_we_i;
  logic msk_we_i;
  logic tmo_we_i;
  logic [INTC_BUS_DW-1:0] bs_wdata_i;
  logic [NCH-1:0] sts_o;
  logic [NCH-1:0] ovf_o;
  logic [NCH-1:0] msk_o;
  logic [TMO_W-1:0] tmo_o;
  modport master (
    output sts_we_i, ovf_we_i, msk_we_i, tmo_we_i, bs_wdata_i,
    input sts_o, ovf_o, msk_o, tmo_o
  );
  modport slave (
    input sts_we_i, ovf_we_i, msk_we_i, tmo_we_i, bs_wdata_i,
    output sts_o, ovf_o, msk_o, tmo_o
  );
endinterface

// File: rtl/dff_rst.sv
// dff_rst: W-bit register with synchronous active-high reset to RST_VL
module dff_rst #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) q <= rst ? RST_VL : d;
endmodule

// File: rtl/intc_evt_det.sv
// intc_evt_det: per-channel event detector, rising edge or level
module intc_evt_det
  import intc_pkg::*;
#(
  parameter intc_mode_e MODE = INTC_EDGE
) (
  input  logic clk,
  input  logic rst,
  input  logic evt,
  output logic set
);
  logic prev;
  dff_rst #(.W(1)) u_prev (.clk(clk), .rst(rst), .d(evt), .q(prev));
  assign set = evt & ((MODE == INTC_LEVEL) | ~prev);
endmodule

// File: rtl/intc_rg_w1c_sts.sv
// intc_rg_w1c_sts: sticky W1C event status with mask, overflow and coalesced irq
module intc_rg_w1c_sts
  import intc_pkg::*;
#(
  parameter int NCH = INTC_NCH_DEF,
  parameter logic [NCH-1:0] EDGE_SEL = {NCH{1'b1}},
  parameter int TMO_W = INTC_TMO_W_DEF,
  parameter logic [NCH-1:0] MSK_RST_VL = {NCH{1'b1}}
) (
  input  logic clk,
  input  logic rst,
  input  logic [NCH-1:0] evt_i,
  input  logic sync_cpu_int_i,
  intc_rg_w1c_sts_if.slave bus,
  output logic irq_o
);
  logic [NCH-1:0] set, wdat, sts_q, ovf_q, msk_q, sts_d, ovf_d, msk_d, sts_clr, ovf_clr;
  logic [TMO_W-1:0] tmo_q, tmo_d, cnt_q, cnt_d;
  logic [TMO_W:0] cnt_inc;
  logic pend_any, irq_d, unused_wdata;
  for (genvar i = 0; i < NCH; i++) begin : g_det
    intc_evt_det #(.MODE(EDGE_SEL[i] ? INTC_EDGE : INTC_LEVEL)) u_det (
      .clk(clk), .rst(rst), .evt(evt_i[i]), .set(set[i])
    );
  end
  assign wdat = bus.bs_wdata_i[NCH-1:0];
  assign unused_wdata = ^bus.bs_wdata_i;
  // new events take priority over every clear source in the same cycle
  always_comb begin
    sts_clr = {NCH{sync_cpu_int_i}} | ({NCH{bus.sts_we_i}} & wdat);
    ovf_clr = {NCH{sync_cpu_int_i}} | ({NCH{bus.ovf_we_i}} & wdat);
    sts_d = set | (sts_q & ~sts_clr);
    ovf_d = (set & sts_q) | (ovf_q & ~ovf_clr);
    msk_d = bus.msk_we_i ? wdat : msk_q;
    tmo_d = bus.tmo_we_i ? bus.bs_wdata_i[TMO_W-1:0] : tmo_q;
    pend_any = |(sts_q & ~msk_q);
    cnt_inc = {1'b0, cnt_q} + 1'b1;
    cnt_d = (!pend_any || irq_o || bus.tmo_we_i) ? '0 : (&cnt_q ? cnt_q : cnt_inc[TMO_W-1:0]);
    irq_d = pend_any & ((tmo_q == '0) | (cnt_inc >= {1'b0, tmo_q}));
  end
  dff_rst #(.W(NCH)) u_sts (.clk(clk), .rst(rst), .d(sts_d), .q(sts_q));
  dff_rst #(.W(NCH)) u_ovf (.clk(clk), .rst(rst), .d(ovf_d), .q(ovf_q));
  dff_rst #(.W(NCH), .RST_VL(MSK_RST_VL)) u_msk (.clk(clk), .rst(rst), .d(msk_d), .q(msk_q));
  dff_rst #(.W(TMO_W)) u_tmo (.clk(clk), .rst(rst), .d(tmo_d), .q(tmo_q));
  dff_rst #(.W(TMO_W)) u_cnt (.clk(clk), .rst(rst), .d(cnt_d), .q(cnt_q));
  dff_rst #(.W(1)) u_irq (.clk(clk), .rst(rst), .d(irq_d), .q(irq_o));
  assign bus.sts_o = sts_q;
  assign bus.ovf_o = ovf_q;
  assign bus.msk_o = msk_q;
  assign bus.tmo_o = tmo_q;
endmodule

// File: tb/tb_intc_rg_w1c_sts.sv
// tb_intc_rg_w1c_sts: scoreboard bench, reference model predicts each cycle's registers
module tb_intc_rg_w1c_sts;
  import intc_pkg::*;
  localparam int NCH = 8;
  localparam int TMO_W = 8;
  localparam logic [7:0] EDGE_SEL = 8'hFB;
  localparam logic [7:0] MSK_RST = 8'hFF;
  typedef struct packed {
    logic [7:0] sts;
    logic [7:0] ovf;
    logic [7:0] msk;
    logic [7:0] tmo;
    logic irq;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] evt = '0;
  logic sync = 1'b0;
  logic irq;
  exp_t sb[$];
  logic [7:0] m_sts, m_ovf, m_msk, m_tmo, m_cnt, m_prev;
  logic m_irq;
  int n_vec = 0;
  int n_err = 0;
  intc_rg_w1c_sts_if #(.NCH(NCH), .TMO_W(TMO_W)) bus ();
  intc_rg_w1c_sts #(.NCH(NCH), .EDGE_SEL(EDGE_SEL), .TMO_W(TMO_W), .MSK_RST_VL(MSK_RST)) dut (
    .clk(clk), .rst(rst), .evt_i(evt), .sync_cpu_int_i(sync), .bus(bus), .irq_o(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // predict the state after the coming edge, then compare once it has happened
  task automatic step();
    exp_t e;
    logic [7:0] wd, set, n_sts, n_ovf;
    logic pend;
    int nxt;
    wd = bus.bs_wdata_i[7:0];
    if (rst) begin
      m_sts = 0; m_ovf = 0; m_msk = MSK_RST; m_tmo = 0; m_cnt = 0; m_irq = 0; m_prev = 0;
    end else begin
      for (int i = 0; i < NCH; i++)
        set[i] = EDGE_SEL[i] ? (evt[i] && !m_prev[i]) : evt[i];
      n_sts = m_sts;
      n_ovf = m_ovf;
      for (int i = 0; i < NCH; i++) begin
        if (set[i]) n_sts[i] = 1'b1;
        else if (sync || (bus.sts_we_i && wd[i])) n_sts[i] = 1'b0;
        if (set[i] && m_sts[i]) n_ovf[i] = 1'b1;
        else if (sync || (bus.ovf_we_i && wd[i])) n_ovf[i] = 1'b0;
      end
      pend = (m_sts & ~m_msk) != 0;
      nxt = int'(m_cnt) + 1;
      if (!pend || m_irq || bus.tmo_we_i) m_cnt = 0;
      else if (m_cnt != 8'hFF) m_cnt = m_cnt + 1;
      m_irq = pend && (m_tmo == 0 || nxt >= int'(m_tmo));
      if (bus.msk_we_i) m_msk = wd;
      if (bus.tmo_we_i) m_tmo = wd;
      m_sts = n_sts;
      m_ovf = n_ovf;
      m_prev = evt;
    end
    sb.push_back('{sts: m_sts, ovf: m_ovf, msk: m_msk, tmo: m_tmo, irq: m_irq});
    @(posedge clk);
    #1;
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("sts", bus.sts_o, e.sts);
      chk("ovf", bus.ovf_o, e.ovf);
      chk("msk", bus.msk_o, e.msk);
      chk("tmo", bus.tmo_o, e.tmo);
      chk("irq", irq, e.irq);
    end
    bus.sts_we_i = 0; bus.ovf_we_i = 0; bus.msk_we_i = 0; bus.tmo_we_i = 0;
    bus.bs_wdata_i = 0; sync = 0;
  endtask
  task automatic wr(input logic s, input logic o, input logic m, input logic t, input logic [7:0] d);
    bus.sts_we_i = s; bus.ovf_we_i = o; bus.msk_we_i = m; bus.tmo_we_i = t;
    bus.bs_wdata_i = {24'h0, d};
  endtask
  initial begin
    wr(0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_sts", bus.sts_o, 0);
    chk("rst_msk", bus.msk_o, MSK_RST);
    chk("rst_irq", irq, 0);
    rst = 0;
    wr(0, 0, 1, 0, 8'h00); step();
    evt = 8'h08; step();
    chk("t1_sts", bus.sts_o, 8'h08);
    chk("t1_irq0", irq, 0);
    evt = 0; step();
    chk("t1_irq1", irq, 1);
    wr(1, 0, 0, 0, 8'h08); step();
    chk("t1_clr", bus.sts_o, 0);
    step();
    chk("t1_irq_fall", irq, 0);
    evt = 8'h08; step();
    evt = 0; step();
    evt = 8'h08; step();
    chk("t2_ovf", bus.ovf_o, 8'h08);
    evt = 0; wr(0, 1, 0, 0, 8'h08); step();
    chk("t2_ovf_clr", bus.ovf_o, 0);
    wr(1, 0, 0, 0, 8'h08); step();
    step();
    evt = 8'h02; wr(1, 0, 0, 0, 8'h02); step();
    chk("t3_set_wins", bus.sts_o[1], 1);
    evt = 0; step();
    sync = 1; step();
    chk("t3_sync_sts", bus.sts_o, 0);
    chk("t3_sync_ovf", bus.ovf_o, 0);
    wr(0, 0, 1, 0, 8'hFF); step();
    evt = 8'hFF; step();
    chk("t4_sts", bus.sts_o, 8'hFF);
    evt = 0; step(); step();
    chk("t4_masked", irq, 0);
    wr(0, 0, 1, 0, 8'hFE); step();
    step();
    chk("t4_unmask", irq, 1);
    sync = 1; wr(0, 0, 1, 1, 8'h00); step();
    wr(0, 0, 0, 1, 8'h05); step();
    chk("t5_tmo", bus.tmo_o, 5);
    evt = 8'h01; step();
    evt = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t5_early", irq, 0);
    end
    step();
    chk("t5_rise", irq, 1);
    sync = 1; step(); step(); step();
    evt = 8'h01; step();
    evt = 0; step(); step(); step();
    wr(1, 0, 0, 0, 8'h01); step();
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t5_never", irq, 0);
    end
    wr(0, 0, 0, 1, 8'h00); step();
    evt = 8'h04; step();
    step();
    chk("t6_ovf", bus.ovf_o[2], 1);
    wr(1, 0, 0, 0, 8'h04); step();
    chk("t6_level", bus.sts_o[2], 1);
    evt = 8'h0C; step();
    rst = 1; step();
    chk("t6_rst_sts", bus.sts_o, 0);
    chk("t6_rst_msk", bus.msk_o, MSK_RST);
    chk("t6_rst_irq", irq, 0);
    rst = 0; step();
    chk("t6_edge_out_of_rst", bus.sts_o[3], 1);
    evt = 0; sync = 1; wr(0, 0, 1, 0, 8'h00); step();
    for (int k = 0; k < 80; k++) begin
      evt = 8'($urandom);
      sync = ($urandom_range(0, 9) == 0);
      wr($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
         $urandom_range(0, 7) == 0, 8'($urandom));
      if (bus.tmo_we_i) bus.bs_wdata_i = 32'($urandom_range(0, 6));
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
